fetch_ctrl: RTL and testbench

- Instruction-fetch and sequencing controller that drives the program counter's control inputs: branch_en, branch_pc and stop_en.
- Takes the current pc, reads the instruction word from a synchronous instruction memory through a req/ack handshake, and decodes flow-control opcodes.
- Holds the PC stopped while a fetch is outstanding and releases it for exactly one cycle per retired instruction.
- Passes non-flow-control instructions downstream with a valid strobe.

---
 rtl/fetch_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch/sequence controller driving PC branch_en/branch_pc/stop_en; FETCH_TIMEOUT_EN adds a bounded ack wait.
// Latency >=3 cycles/instr (FETCH>=1, EXEC 1, SETTLE 1); imem_req held until imem_ack, PC held via stop_en meanwhile.
module fetch_ctrl #(
   parameter int AW      = 8,
   parameter int IW      = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          power,
   input  logic [AW-1:0] pc,
   input  logic          flag_z,
   input  logic          resume,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [IW-1:0] imem_rdata,
   output logic          branch_en,
   output logic [AW-1:0] branch_pc,
   output logic          stop_en,
   output logic [IW-1:0] instr,
   output logic          instr_valid,
   output logic          halted,
   output logic [15:0]   instr_count,
   output logic          fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_SETTLE,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_JZ   = 4'hD;
   localparam logic [3:0] OP_JNZ  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   state_t        r_state, w_state_nxt;
   logic          r_req, w_req_nxt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic          r_ben, w_ben_nxt;
   logic [AW-1:0] r_bpc, w_bpc_nxt;
   logic          r_stop, w_stop_nxt;
   logic [IW-1:0] r_instr, w_instr_nxt;
   logic          r_valid, w_valid_nxt;
   logic          r_halted, w_halted_nxt;
   logic [15:0]   r_count, w_count_nxt;

   logic [3:0]    w_op;
   logic          w_taken;

   assign w_op    = imem_rdata[IW-1:IW-4];
   assign w_taken = (w_op == OP_JMP) ||
                    ((w_op == OP_JZ)  &&  flag_z) ||
                    ((w_op == OP_JNZ) && !flag_z);

`ifdef FETCH_TIMEOUT_EN
   logic [3:0] r_wait, w_wait_nxt;
   logic       r_err, w_err_nxt;
   logic       r_to_halt, w_to_halt_nxt;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_req_nxt    = r_req;
      w_addr_nxt   = r_addr;
      w_ben_nxt    = 1'b0;
      w_bpc_nxt    = r_bpc;
      w_stop_nxt   = 1'b1;
      w_instr_nxt  = r_instr;
      w_valid_nxt  = 1'b0;
      w_halted_nxt = r_halted;
      w_count_nxt  = r_count;
`ifdef FETCH_TIMEOUT_EN
      w_wait_nxt    = r_wait;
      w_err_nxt     = r_err;
      w_to_halt_nxt = r_to_halt;
`endif
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_FETCH;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = pc;
`ifdef FETCH_TIMEOUT_EN
            w_wait_nxt  = 4'd0;
`endif
         end
         S_FETCH: begin
            if (imem_ack) begin
               w_req_nxt   = 1'b0;
               w_instr_nxt = imem_rdata;
               if (w_op == OP_HALT) begin
                  w_state_nxt  = S_HALT;
                  w_halted_nxt = 1'b1;
               end else begin
                  // Outputs are registered, so EXEC's strobes are loaded on the ack edge.
                  w_state_nxt = S_EXEC;
                  w_stop_nxt  = 1'b0;
                  w_valid_nxt = 1'b1;
                  w_count_nxt = r_count + 16'd1;
                  if (w_taken) begin
                     w_ben_nxt = 1'b1;
                     w_bpc_nxt = imem_rdata[AW-1:0];
                  end
               end
            end
`ifdef FETCH_TIMEOUT_EN
            else if (r_wait == 4'(TIMEOUT - 1)) begin
               w_state_nxt   = S_HALT;
               w_req_nxt     = 1'b0;
               w_halted_nxt  = 1'b1;
               w_err_nxt     = 1'b1;
               w_to_halt_nxt = 1'b1;
            end else begin
               w_wait_nxt = r_wait + 4'd1;
            end
`endif
         end
         S_EXEC: begin
            w_state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            w_state_nxt = S_FETCH;
            w_req_nxt   = 1'b1;
            w_addr_nxt  = pc;
`ifdef FETCH_TIMEOUT_EN
            w_wait_nxt  = 4'd0;
`endif
         end
         S_HALT: begin
            if (resume) begin
               w_halted_nxt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
               if (r_to_halt) begin
                  // A timed-out fetch is retried at the same PC rather than stepped past.
                  w_state_nxt   = S_FETCH;
                  w_req_nxt     = 1'b1;
                  w_addr_nxt    = pc;
                  w_wait_nxt    = 4'd0;
                  w_to_halt_nxt = 1'b0;
               end else begin
                  w_state_nxt = S_EXEC;
                  w_stop_nxt  = 1'b0;
               end
`else
               w_state_nxt = S_EXEC;
               w_stop_nxt  = 1'b0;
`endif
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge power) begin
      if (!power) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge power) begin
      if (!power) begin
         r_req    <= 1'b0;
         r_addr   <= '0;
         r_ben    <= 1'b0;
         r_bpc    <= '0;
         r_stop   <= 1'b1;
         r_instr  <= '0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
         r_count  <= 16'd0;
      end else begin
         r_req    <= w_req_nxt;
         r_addr   <= w_addr_nxt;
         r_ben    <= w_ben_nxt;
         r_bpc    <= w_bpc_nxt;
         r_stop   <= w_stop_nxt;
         r_instr  <= w_instr_nxt;
         r_valid  <= w_valid_nxt;
         r_halted <= w_halted_nxt;
         r_count  <= w_count_nxt;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clk or negedge power) begin
      if (!power) begin
         r_wait    <= 4'd0;
         r_err     <= 1'b0;
         r_to_halt <= 1'b0;
      end else begin
         r_wait    <= w_wait_nxt;
         r_err     <= w_err_nxt;
         r_to_halt <= w_to_halt_nxt;
      end
   end

   assign fetch_err = r_err;
`else
   assign fetch_err = 1'b0;
`endif

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign branch_en   = r_ben;
   assign branch_pc   = r_bpc;
   assign stop_en     = r_stop;
   assign instr       = r_instr;
   assign instr_valid = r_valid;
   assign halted      = r_halted;
   assign instr_count = r_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: random program + latency-randomised memory, ISA-level reference model, scoreboard monitor.
module tb_fetch_ctrl;
   localparam int AW = 8;
   localparam int IW = 16;

   logic          clk = 1'b0;
   logic          power = 1'b0;
   logic [AW-1:0] pc;
   logic          flag_z = 1'b0;
   logic          resume = 1'b0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [IW-1:0] imem_rdata = '0;
   logic          branch_en;
   logic [AW-1:0] branch_pc;
   logic          stop_en;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          halted;
   logic [15:0]   instr_count;
   logic          fetch_err;

   fetch_ctrl #(.AW(AW), .IW(IW), .TIMEOUT(15)) dut (
      .clk(clk), .power(power), .pc(pc), .flag_z(flag_z), .resume(resume),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .branch_en(branch_en), .branch_pc(branch_pc), .stop_en(stop_en), .instr(instr),
      .instr_valid(instr_valid), .halted(halted), .instr_count(instr_count), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   // Program counter the controller steers.
   always @(posedge clk or negedge power) begin
      if (!power)         pc <= '0;
      else if (branch_en) pc <= branch_pc;
      else if (!stop_en)  pc <= pc + 8'd1;
   end

   typedef struct packed {
      logic          valid;
      logic          taken;
      logic [AW-1:0] tgt;
      logic [IW-1:0] word;
      logic [15:0]   cnt;
   } exp_t;

   exp_t          sb[$];
   exp_t          me;
   logic [IW-1:0] mem [256];
   logic [AW-1:0] ref_pc = '0;
   logic [15:0]   ref_count = '0;
   int            errors = 0, checks = 0, pops = 0;
   bit            waiting = 0, silent = 0, auto_res = 1, to_halt = 0, first_halt = 1;
   int            dly = 0, hold = 1, halt_n = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [IW-1:0] rand_word();
      int r;
      logic [3:0] op;
      logic [11:0] rest;
      r = $urandom_range(0, 99);
      rest = 12'($urandom);
      if (r < 50)      op = 4'($urandom_range(0, 11));
      else if (r < 65) op = 4'hC;
      else if (r < 77) op = 4'hD;
      else if (r < 89) op = 4'hE;
      else             op = 4'hF;
      return {op, rest};
   endfunction

   // Architectural model: every accepted fetch must come from the PC the program implies.
   task automatic model_fetch(input logic [IW-1:0] word, input logic z);
      logic [3:0] op;
      logic taken;
      chk("fetch_addr", 32'(imem_addr), 32'(ref_pc));
      op = word[15:12];
      if (op != 4'hF) begin
         taken = (op == 4'hC) || (op == 4'hD && z) || (op == 4'hE && !z);
         ref_count = ref_count + 16'd1;
         sb.push_back('{valid: 1'b1, taken: taken, tgt: word[AW-1:0], word: word, cnt: ref_count});
         ref_pc = taken ? word[AW-1:0] : ref_pc + 8'd1;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
      resume = 1'b0;
      if (!power) begin
         imem_ack = 1'b0;
         waiting  = 0;
         return;
      end
      flag_z = 1'($urandom_range(0, 1));
      if (imem_ack) begin
         imem_ack = 1'b0;
      end else if (imem_req && !silent) begin
         if (!waiting) begin
            waiting = 1;
            dly = $urandom_range(0, 3);
         end
         if (dly == 0) begin
            waiting    = 0;
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr];
            model_fetch(imem_rdata, flag_z);
         end else begin
            dly--;
         end
      end
      if (halted && auto_res) begin
         halt_n++;
         if (halt_n == 1) hold = first_halt ? 20 : $urandom_range(1, 4);
         if (halt_n >= hold) begin
            chk("halt_count", 32'(instr_count), 32'(ref_count));
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_stop", 32'(stop_en), 32'd1);
            resume = 1'b1;
            halt_n = 0;
            first_halt = 0;
            if (to_halt) begin
               to_halt = 0;
            end else begin
               sb.push_back('{valid: 1'b0, taken: 1'b0, tgt: '0, word: '0, cnt: ref_count});
               ref_pc = ref_pc + 8'd1;
            end
         end
      end else if (!halted) begin
         halt_n = 0;
         // resume outside HALT must do nothing
         if ($urandom_range(0, 15) == 0) resume = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      power = 1'b0;
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_ben", 32'(branch_en), 32'd0);
      chk("rst_bpc", 32'(branch_pc), 32'd0);
      chk("rst_stop", 32'(stop_en), 32'd1);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      sb.delete();
      ref_pc = '0;
      ref_count = '0;
      waiting = 0;
      imem_ack = 1'b0;
      resume = 1'b0;
      halt_n = 0;
      to_halt = 0;
      repeat (2) @(posedge clk);
      #1;
      power = 1'b1;
      for (int i = 0; i < 2 && !imem_req; i++) cycle();
      chk("req_after_reset", 32'(imem_req), 32'd1);
      chk("addr_after_reset", 32'(imem_addr), 32'(pc));
   endtask

   always @(negedge clk) begin
      if (power) begin
         if (stop_en) begin
            chk("ben_while_stop", 32'(branch_en), 32'd0);
         end else if (sb.size() == 0) begin
            chk("unexpected_release", 32'(stop_en), 32'd1);
         end else begin
            me = sb.pop_front();
            pops++;
            chk("exec_valid", 32'(instr_valid), 32'(me.valid));
            if (me.valid) chk("exec_instr", 32'(instr), 32'(me.word));
            chk("exec_ben", 32'(branch_en), 32'(me.taken));
            if (me.taken) chk("exec_bpc", 32'(branch_pc), 32'(me.tgt));
            chk("exec_count", 32'(instr_count), 32'(me.cnt));
            chk("exec_halted", 32'(halted), 32'd0);
         end
      end
   end

   initial begin
      int req_cycles;
      int pops_before;
      for (int i = 0; i < 256; i++) mem[i] = rand_word();
      mem[8'h00] = 16'hC010;
      mem[8'h10] = 16'h1234;
      mem[8'h11] = 16'hC080;
      mem[8'h80] = 16'hD040;
      mem[8'h81] = 16'hE040;
      mem[8'h40] = 16'hE040;
      mem[8'h41] = 16'hF000;

      do_reset();
      repeat (400) cycle();
      do_reset();
      repeat (600) cycle();

`ifdef FETCH_TIMEOUT_EN
      silent = 1;
      auto_res = 0;
      do_reset();
      req_cycles = imem_req ? 1 : 0;
      for (int i = 0; i < 40 && !halted; i++) begin
         cycle();
         if (imem_req) req_cycles++;
      end
      chk("to_fetch_cycles", 32'(req_cycles), 32'd15);
      chk("to_err", 32'(fetch_err), 32'd1);
      chk("to_halted", 32'(halted), 32'd1);
      chk("to_req", 32'(imem_req), 32'd0);
      pops_before = pops;
      to_halt = 1;
      silent = 0;
      auto_res = 1;
      repeat (40) cycle();
      chk("to_err_sticky", 32'(fetch_err), 32'd1);
      chk("to_retry_progress", 32'(pops > pops_before), 32'd1);
      do_reset();
      repeat (200) cycle();
`else
      req_cycles = 0;
      pops_before = pops;
      chk("fetch_err_tied", 32'(fetch_err), 32'(req_cycles));
`endif

      silent = 1;
      auto_res = 0;
      repeat (6) cycle();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("retired_enough", 32'(pops >= 50), 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
